// File: rtl/vsp_if.sv
// Bus bundle for vsp_core: program-memory fetch port, valid/ready input port
// and strobed output port.
interface vsp_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0]   imem_addr;
  logic [DATA_W+4:0]   imem_data;
  logic [DATA_W-1:0]   indata;
  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   outdata;
  logic                out_strobe;

  modport master (
    output imem_addr,
    input  imem_data,
    input  indata,
    input  in_valid,
    output in_ready,
    output outdata,
    output out_strobe
  );

  modport slave (
    input  imem_addr,
    output imem_data,
    output indata,
    output in_valid,
    input  in_ready,
    input  outdata,
    input  out_strobe
  );
endinterface

// File: rtl/vsp_core.sv
// Parametrised accumulator processor: FETCH/EXEC/WAIT_IN/HALT, C/Z flags, jumps.
// Optional internal data memory for LD/ST is built when VSP_DMEM_EN is defined.
module vsp_core #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int DMEM_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  vsp_if.master             bus,
  output logic [DATA_W-1:0] a_value,
  output logic [ADDR_W-1:0] pc_value,
  output logic [DATA_W+4:0] ir_value,
  output logic [1:0]        flags,
  output logic              halted
);
  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_WAIT_IN, S_HALT} state_t;

  localparam logic [4:0] OP_LDI = 5'h01;
  localparam logic [4:0] OP_ADD = 5'h02;
  localparam logic [4:0] OP_SUB = 5'h03;
  localparam logic [4:0] OP_AND = 5'h04;
  localparam logic [4:0] OP_OR  = 5'h05;
  localparam logic [4:0] OP_XOR = 5'h06;
  localparam logic [4:0] OP_IN  = 5'h07;
  localparam logic [4:0] OP_OUT = 5'h08;
  localparam logic [4:0] OP_JMP = 5'h09;
  localparam logic [4:0] OP_JZ  = 5'h0A;
  localparam logic [4:0] OP_JC  = 5'h0B;
  localparam logic [4:0] OP_LD  = 5'h0C;
  localparam logic [4:0] OP_ST  = 5'h0D;
  localparam logic [4:0] OP_HLT = 5'h1F;

  state_t            state_reg;
  logic [DATA_W-1:0] a_reg;
  logic [DATA_W-1:0] out_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [DATA_W+4:0] ir_reg;
  logic              c_reg;
  logic              z_reg;
  logic              strobe_reg;
  logic              ready_reg;
  logic              halted_reg;

  logic [4:0]        op;
  logic [DATA_W-1:0] imm;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] a_next;
  logic              a_wr;
  logic              c_next;
  logic              jump;
  logic [DATA_W-1:0] ld_data;

  assign op  = ir_reg[DATA_W+4:DATA_W];
  assign imm = ir_reg[DATA_W-1:0];

`ifdef VSP_DMEM_EN
  localparam bit DMEM_EN = 1'b1;
  logic [DATA_W-1:0]  dmem_word [2**DMEM_AW];
  logic [DMEM_AW-1:0] dmem_addr;
  logic               st_en;

  assign dmem_addr = imm[DMEM_AW-1:0];
  assign st_en     = (state_reg == S_EXEC) && (op == OP_ST);
  assign ld_data   = dmem_word[dmem_addr];

  genvar gi;
  generate
    for (gi = 0; gi < 2**DMEM_AW; gi++) begin : g_dmem
      logic [DATA_W-1:0] word_reg;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          word_reg <= '0;
        end else if (st_en && (dmem_addr == DMEM_AW'(gi))) begin
          word_reg <= a_reg;
        end
      end
      assign dmem_word[gi] = word_reg;
    end
  endgenerate
`else
  localparam bit DMEM_EN = 1'b0;
  logic unused_dmem_aw;
  assign unused_dmem_aw = (DMEM_AW != 0);
  assign ld_data        = '0;
`endif

  // Sum/difference carry one extra bit; for SUB the top bit is the borrow.
  always_comb begin
    sum    = {1'b0, a_reg} + {1'b0, imm};
    diff   = {1'b0, a_reg} - {1'b0, imm};
    a_next = a_reg;
    a_wr   = 1'b0;
    c_next = c_reg;
    jump   = 1'b0;
    case (op)
      OP_LDI: begin a_next = imm; a_wr = 1'b1; end
      OP_ADD: begin a_next = sum[DATA_W-1:0];  c_next = sum[DATA_W];  a_wr = 1'b1; end
      OP_SUB: begin a_next = diff[DATA_W-1:0]; c_next = diff[DATA_W]; a_wr = 1'b1; end
      OP_AND: begin a_next = a_reg & imm; a_wr = 1'b1; end
      OP_OR:  begin a_next = a_reg | imm; a_wr = 1'b1; end
      OP_XOR: begin a_next = a_reg ^ imm; a_wr = 1'b1; end
      OP_LD:  begin
        if (DMEM_EN) begin
          a_next = ld_data;
          a_wr   = 1'b1;
        end
      end
      OP_JMP: jump = 1'b1;
      OP_JZ:  jump = z_reg;
      OP_JC:  jump = c_reg;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= S_FETCH;
      a_reg      <= '0;
      out_reg    <= '0;
      pc_reg     <= '0;
      ir_reg     <= '0;
      c_reg      <= 1'b0;
      z_reg      <= 1'b0;
      strobe_reg <= 1'b0;
      ready_reg  <= 1'b0;
      halted_reg <= 1'b0;
    end else begin
      strobe_reg <= 1'b0;
      case (state_reg)
        S_FETCH: begin
          ir_reg    <= bus.imem_data;
          pc_reg    <= pc_reg + ADDR_W'(1);
          state_reg <= S_EXEC;
        end
        S_EXEC: begin
          state_reg <= S_FETCH;
          c_reg     <= c_next;
          if (a_wr) begin
            a_reg <= a_next;
            z_reg <= (a_next == '0);
          end
          // PC already points past this instruction; a taken jump replaces it.
          if (jump) pc_reg <= imm[ADDR_W-1:0];
          case (op)
            OP_IN: begin
              state_reg <= S_WAIT_IN;
              ready_reg <= 1'b1;
            end
            OP_OUT: begin
              out_reg    <= a_reg;
              strobe_reg <= 1'b1;
            end
            OP_HLT: begin
              state_reg  <= S_HALT;
              halted_reg <= 1'b1;
            end
            default: ;
          endcase
        end
        S_WAIT_IN: begin
          if (bus.in_valid) begin
            a_reg     <= bus.indata;
            z_reg     <= (bus.indata == '0);
            ready_reg <= 1'b0;
            state_reg <= S_FETCH;
          end
        end
        S_HALT: ;
        default: state_reg <= S_FETCH;
      endcase
    end
  end

  assign bus.imem_addr  = pc_reg;
  assign bus.in_ready   = ready_reg;
  assign bus.outdata    = out_reg;
  assign bus.out_strobe = strobe_reg;
  assign a_value        = a_reg;
  assign pc_value       = pc_reg;
  assign ir_value       = ir_reg;
  assign flags          = {c_reg, z_reg};
  assign halted         = halted_reg;
endmodule

// File: doc/vsp_core.md
# vsp_core

Parametrised successor to the 8-bit very simple processor: an accumulator machine with configurable data and program-address width. It adds carry/zero flags, conditional jumps, halt, a valid/ready input handshake, an output strobe and an optional internal data memory. It fetches from an external, combinationally read program memory and exposes its architectural state (A, PC, IR) for debug and testbenches.

## Interface

Parameters:
- DATA_W, 8, accumulator, operand and I/O width
- ADDR_W, 8, program-counter and program-memory address width (requires ADDR_W ≤ DATA_W)
- DMEM_AW, 4, data-memory address width (2^DMEM_AW words); used only with VSP_DMEM_EN

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- imem_addr  out  ADDR_W  program-memory address; equals pc_value
- imem_data  in  5+DATA_W  instruction word, combinational read: {opcode[4:0], operand[DATA_W-1:0]}
- indata  in  DATA_W  input port data
- in_valid  in  1  indata is valid
- in_ready  out  1  core is accepting input
- outdata  out  DATA_W  registered output port
- out_strobe  out  1  one-cycle pulse when outdata is updated
- a_value  out  DATA_W  accumulator
- pc_value  out  ADDR_W  program counter
- ir_value  out  5+DATA_W  instruction register
- flags  out  2  {C, Z}
- halted  out  1  core is in HALT

## Operation

- FSM states and transitions:
  - FETCH: IR ← imem_data, PC ← PC+1. Next state is EXEC.
  - EXEC: execute IR. Next state is FETCH; WAIT_IN for IN; HALT for HLT.
  - WAIT_IN: hold until input is accepted, then FETCH.
  - HALT: absorbing until reset.
- Opcodes (imm = operand):
  - 00 NOP
  - 01 LDI: A ← imm
  - 02 ADD: {C,A} ← A+imm
  - 03 SUB: {C,A} ← A−imm; C=1 on borrow
  - 04 AND, 05 OR, 06 XOR: A ← A op imm
  - 07 IN: enter WAIT_IN; A ← indata on accept
  - 08 OUT: outdata ← A, out_strobe pulses
  - 09 JMP: PC ← imm[ADDR_W-1:0]
  - 0A JZ: jump if Z=1
  - 0B JC: jump if C=1
  - 0C LD: A ← dmem[imm[DMEM_AW-1:0]]
  - 0D ST: dmem[imm[DMEM_AW-1:0]] ← A
  - 1F HLT
  - All other opcodes execute as NOP.
- Flags:
  - Z ← (A_new == 0) on LDI, ADD, SUB, AND, OR, XOR, IN and LD.
  - C changes only on ADD and SUB.
  - All other instructions leave the flags unchanged.
- Arithmetic:
  - ADD/SUB are computed at DATA_W+1 bits; A keeps the low DATA_W bits.
  - PC wraps modulo 2^ADDR_W; 2^ADDR_W−1 + 1 = 0.
- Jump targets truncate the operand to ADDR_W bits. A taken jump overrides the increment done in FETCH.
- Handshake:
  - in_ready=1 exactly in WAIT_IN.
  - Transfer happens at the edge where in_valid & in_ready; A and Z update, then the FSM goes to FETCH.
  - in_valid asserted outside WAIT_IN is ignored; nothing is buffered.

## Timing

- Reset (rst=0, asynchronous) clears:
  - A, PC, IR, outdata, flags and dmem to 0
  - out_strobe, in_ready and halted to 0
  - state to FETCH
- Releasing reset: the first fetch of address 0 happens on the first rising edge after rst goes high.
- Latency: 2 cycles per instruction; IN takes 2 + wait cycles.
  - Result registers update on the EXEC edge.
  - out_strobe is high for the cycle after the OUT EXEC edge.
- halted rises on the HLT EXEC edge. PC keeps its value (address of HLT + 1).
- Reset asserted mid-instruction or in WAIT_IN/HALT aborts immediately. A pending dmem write is discarded.
- imem_data must be stable during FETCH. It is sampled only at the FETCH edge.

## Configuration

- VSP_DMEM_EN defined:
  - Internal data memory of 2^DMEM_AW × DATA_W registers.
  - Synchronous write on the ST EXEC edge.
  - Combinational read for LD.
- VSP_DMEM_EN undefined:
  - No data memory is generated.
  - LD and ST execute as NOP; A and the flags are unchanged.

## Test plan

- Reset with rst=0 held 10 cycles and random in_valid/indata -> all outputs 0; imem_addr=0; no strobe.
- LDI 05; ADD FE; JC 05 -> A=03, C=1, Z=0; PC=05 after jump; SUB 03 gives A=00, Z=1, C=0.
- IN with in_valid low 7 cycles, then indata=0C -> in_ready high 7+1 cycles; A=0C; pc_value advances only after accept.
- LDI AA; OUT; HLT -> outdata=AA; out_strobe high exactly 1 cycle; halted=1; PC frozen for 50 cycles.
- JMP FF with ADDR_W=8 -> next fetch at FF, then wrap to 00; reset asserted mid-EXEC clears A and PC within the same cycle.
- With VSP_DMEM_EN: LDI 3C; ST 02; LDI 00; LD 02 -> A=3C, Z=0. Without the macro: A=00.
